mult_seq_ctrl: RTL and testbench

Sequencing and arbitration controller for the ALU's shared multiplier. Accepts multiply requests from two requesters, picks one with round-robin arbitration, and computes a full 2·WIDTH-bit product. It uses an iterative radix-2 shift-add datapath, with signed or unsigned operands. The finished product is presented with a one-cycle `mult_en` strobe for the downstream result register, which loads on `mult_en` and clears otherwise.

---
 rtl/mult_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// Shared-multiplier controller: round-robin arbitration between two requesters
// feeding an iterative radix-2 shift-add multiplier with signed/unsigned operands.
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_signed,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_signed,
    output logic             req1_ready,
    output logic             busy,
    output logic             res_valid,
    output logic             res_id,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             mult_en
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               id_q, id_d;
    logic               res_valid_q, res_valid_d;
    logic               res_id_q, res_id_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;

    logic               grant0, grant1;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_signed;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    // Requester 0 wins unless requester 1 is alone or requester 0 was granted last.
    assign grant0 = req0_valid && (!req1_valid || last_q);
    assign grant1 = req1_valid && !grant0;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        a_d         = a_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        id_d        = id_q;
        res_valid_d = 1'b0;
        res_id_d    = res_id_q;
        res_hi_d    = res_hi_q;
        res_lo_d    = res_lo_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        sel_a       = grant1 ? req1_a : req0_a;
        sel_b       = grant1 ? req1_b : req0_b;
        sel_signed  = grant1 ? req1_signed : req0_signed;
        sum         = '0;
        prod        = '0;

        unique case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing is offered while reset is held.
                req0_ready = rst && grant0;
                req1_ready = rst && grant1;
                if (grant0 || grant1) begin
                    a_d     = (sel_signed && sel_a[WIDTH-1]) ? -sel_a : sel_a;
                    acc_d   = {{WIDTH{1'b0}},
                               (sel_signed && sel_b[WIDTH-1]) ? -sel_b : sel_b};
                    neg_d   = sel_signed && (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
                    id_d    = grant1;
                    last_d  = grant1;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                prod        = neg_q ? -acc_q : acc_q;
                res_hi_d    = prod[2*WIDTH-1:WIDTH];
                res_lo_d    = prod[WIDTH-1:0];
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_hi_q    <= '0;
            res_lo_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_hi_q    <= res_hi_d;
            res_lo_q    <= res_lo_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = res_valid_q;
    assign mult_en   = res_valid_q;
    assign res_id    = res_id_q;
    assign res_hi    = res_hi_q;
    assign res_lo    = res_lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed self-checking bench for mult_seq_ctrl (WIDTH = 32): arbitration,
// signed/unsigned products, latency, back-to-back issue and mid-operation reset.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_signed = 1'b0, req1_signed = 1'b0;
    logic         req0_ready, req1_ready, busy, res_valid, res_id, mult_en;
    logic [W-1:0] res_hi, res_lo;

    int checks = 0;
    int errors = 0;

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_signed(req0_signed),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_signed(req1_signed),
        .req1_ready (req1_ready),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_id     (res_id),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .mult_en    (mult_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit s);
        if (id) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_signed = s;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_signed = s;
        end
    endtask

    task automatic wait_ready(input string tag, input bit id);
        int n = 0;
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'd1);
    endtask

    // Called in the accepting cycle; returns in the res_valid cycle.
    task automatic wait_result(input string tag, input bit exp_id, input logic [63:0] exp_p);
        int lat = 0;
        tick();
        check({tag, "_busy"}, 64'(busy), 64'd1);
        while (!res_valid && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(W + 1));
        check({tag, "_mult_en"}, 64'(mult_en), 64'd1);
        check({tag, "_id"}, 64'(res_id), 64'(exp_id));
        check({tag, "_product"}, {res_hi, res_lo}, exp_p);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int hits;

        // Reset state, both requesters already asking.
        set_req(0, 1, 32'd2, 32'd3, 0);
        set_req(1, 1, 32'd4, 32'd5, 0);
        #12;
        check("rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("rst_flags", 64'({busy, res_valid, mult_en, res_id}), 64'd0);
        check("rst_result", {res_hi, res_lo}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Simultaneous: req0 first, req1 back-to-back in the res_valid cycle.
        #1;
        check("sim_grant0", 64'({req1_ready, req0_ready}), 64'd1);
        wait_result("sim0", 0, 64'd6);
        check("sim_b2b_grant1", 64'({req1_ready, req0_ready}), 64'd2);
        req0_valid = 1'b0;
        wait_result("sim1", 1, 64'd20);
        req1_valid = 1'b0;
        tick();

        // Unsigned max * max and one-cycle strobe.
        set_req(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_ready("uns", 0);
        wait_result("uns", 0, 64'hFFFF_FFFE_0000_0001);
        req0_valid = 1'b0;
        tick();
        check("uns_strobe_off", 64'({res_valid, mult_en}), 64'd0);
        check("uns_hold", {res_hi, res_lo}, 64'hFFFF_FFFE_0000_0001);

        // Signed corners.
        set_req(1, 1, 32'h8000_0000, 32'h8000_0000, 1);
        wait_ready("smin", 1);
        wait_result("smin", 1, 64'h4000_0000_0000_0000);
        req1_valid = 1'b0;
        tick();
        set_req(1, 1, 32'hFFFF_FFFD, 32'd7, 1);
        wait_ready("sneg", 1);
        wait_result("sneg", 1, 64'hFFFF_FFFF_FFFF_FFEB);
        req1_valid = 1'b0;
        tick();

        // Fairness: both held for six operations, grants alternate from 0.
        set_req(0, 1, 32'd10, 32'd11, 0);
        set_req(1, 1, 32'd12, 32'd13, 0);
        #1;
        for (int i = 0; i < 6; i++) begin
            check("fair_onehot", 64'(req0_ready & req1_ready), 64'd0);
            check("fair_grant", 64'({req1_ready, req0_ready}), (i % 2 == 1) ? 64'd2 : 64'd1);
            wait_result("fair", bit'(i % 2), (i % 2 == 1) ? 64'd156 : 64'd110);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // Zero and identity; results hold while idle.
        set_req(0, 1, 32'd0, 32'h1234_5678, 0);
        wait_ready("zero", 0);
        wait_result("zero", 0, 64'd0);
        req0_valid = 1'b0;
        tick();
        set_req(1, 1, 32'd1, 32'h1234_5678, 1);
        wait_ready("ident", 1);
        wait_result("ident", 1, 64'h0000_0000_1234_5678);
        req1_valid = 1'b0;
        repeat (5) tick();
        check("idle_hold_result", {res_hi, res_lo}, 64'h0000_0000_1234_5678);
        check("idle_hold_flags", 64'({res_valid, res_id}), 64'd1);

        // Reset ten cycles into CALC.
        set_req(0, 1, 32'd5, 32'd6, 0);
        wait_ready("mid", 0);
        tick();
        req0_valid = 1'b0;
        repeat (9) tick();
        check("mid_busy", 64'(busy), 64'd1);
        set_req(1, 1, 32'd7, 32'd9, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'({req1_ready, req0_ready}), 64'd0);
        check("mid_rst_flags", 64'({busy, res_valid, mult_en, res_id}), 64'd0);
        check("mid_rst_result", {res_hi, res_lo}, 64'd0);
        req1_valid = 1'b0;
        tick();
        rst = 1'b1;
        hits = 0;
        repeat (40) begin
            tick();
            if (res_valid) hits++;
        end
        check("mid_no_result", 64'(hits), 64'd0);
        req1_valid = 1'b1;
        wait_ready("post", 1);
        wait_result("post", 1, 64'd63);
        req1_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
